instr_fetch_uni: RTL and testbench

- Instruction fetch front end that produces the instruction stream the control decoder consumes.
- Issues requests to instruction memory over a req/ack interface and buffers returned words with their PCs in a small prefetch queue.
- Presents the head entry to decode over valid/ready, exposing bits 31:21 as the opcode for the control block.
- Flushes and refetches from a new PC on a branch redirect from execute.

---
 rtl/instr_fetch_uni_pkg.sv | 26 ++
 rtl/instr_fetch_uni_fetch_queue.sv | 59 +++++
 rtl/instr_fetch_uni.sv | 124 ++++++++++++
 tb/tb_instr_fetch_uni.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_uni_pkg.sv
// Shared definitions for the instruction fetch front end.
// Holds the fetch FSM state encodings, the reset PC default, the opcode field
// bounds handed to the control unit and the prefetch queue entry layout.
package instr_fetch_uni_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no request outstanding
    ST_REQ  = 2'd1,  // request outstanding, returned word is kept
    ST_DROP = 2'd2   // request outstanding, returned word is discarded
  } fetch_state_e;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_HI  = 31;
  localparam int unsigned OPC_LO  = 21;
  localparam int unsigned OPC_W   = OPC_HI - OPC_LO + 1;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/instr_fetch_uni_fetch_queue.sv
// Prefetch queue: circular buffer of DEPTH fetched instructions with their PCs.
// Ports: i_clk/i_rst_n, i_push + i_data (enqueue), i_pop (dequeue head),
//        i_flush (synchronous clear, wins over push; a same-cycle pop simply
//        completes), o_head (entry at read pointer), o_count (occupancy).
module instr_fetch_uni_fetch_queue
  import instr_fetch_uni_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  fq_entry_t                    i_data,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output fq_entry_t                    o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  fq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = i_push && !i_flush && (r_count != CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Storage needs no reset: the head is only observed while count is nonzero.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_uni.sv
// Instruction fetch front end feeding the control decoder.
// Ports: iCLK/iRST_n; oIMEM_REQ/oIMEM_ADDR/iIMEM_ACK/iIMEM_DATA (memory req/ack);
//        oVALID/iREADY/oINSTR/oOPCODE/oPC (head of prefetch queue to decode);
//        iREDIRECT/iREDIRECT_PC (flush and refetch from a new PC).
module instr_fetch_uni
  import instr_fetch_uni_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 4
) (
  input  logic         iCLK,
  input  logic         iRST_n,
  output logic         oIMEM_REQ,
  output logic [63:0]  oIMEM_ADDR,
  input  logic         iIMEM_ACK,
  input  logic [31:0]  iIMEM_DATA,
  output logic         oVALID,
  input  logic         iREADY,
  output logic [31:0]  oINSTR,
  output logic [10:0]  oOPCODE,
  output logic [63:0]  oPC,
  input  logic         iREDIRECT,
  input  logic [63:0]  iREDIRECT_PC
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_e     r_state;
  fetch_state_e     w_state_next;
  logic [63:0]      r_fetch_pc;
  logic [63:0]      w_fetch_pc_next;
  logic [63:0]      r_drop_pc;     // redirect target waiting for the dropped ack
  logic [63:0]      w_drop_pc_next;
  logic [63:0]      w_redirect_pc;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_count_after_pop;
  fq_entry_t        w_head;
  fq_entry_t        w_push_data;

  assign w_redirect_pc     = iREDIRECT_PC & ~64'h3;
  assign w_valid           = (w_count != '0);
  assign w_pop             = w_valid && iREADY;
  assign w_count_after_pop = w_count - CNT_W'(w_pop);
  assign w_push_data       = '{pc: r_fetch_pc, instr: iIMEM_DATA};

  instr_fetch_uni_fetch_queue #(.DEPTH(DEPTH)) u_fetch_queue (
    .i_clk   (iCLK),
    .i_rst_n (iRST_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (iREDIRECT),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // State, fetch PC and pending redirect target.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_drop_pc  <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_drop_pc  <= w_drop_pc_next;
    end
  end

  // Next state; the fill decision uses the post-dequeue count so fetch
  // restarts right after decode frees a slot.
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_drop_pc_next  = r_drop_pc;
    w_push          = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (iREDIRECT) begin
          w_fetch_pc_next = w_redirect_pc;
          w_state_next    = ST_REQ;
        end else if (w_count_after_pop < CNT_W'(DEPTH)) begin
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (iREDIRECT) begin
          if (iIMEM_ACK) begin
            w_fetch_pc_next = w_redirect_pc;
            w_state_next    = ST_REQ;
          end else begin
            // Keep presenting the abandoned address until memory acks it.
            w_drop_pc_next = w_redirect_pc;
            w_state_next   = ST_DROP;
          end
        end else if (iIMEM_ACK) begin
          w_push          = 1'b1;
          w_fetch_pc_next = r_fetch_pc + 64'd4;
          w_state_next    = ((w_count_after_pop + CNT_W'(1)) < CNT_W'(DEPTH)) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (iREDIRECT) w_drop_pc_next = w_redirect_pc;
        if (iIMEM_ACK) begin
          w_fetch_pc_next = iREDIRECT ? w_redirect_pc : r_drop_pc;
          w_state_next    = ST_REQ;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign oIMEM_REQ  = (r_state == ST_REQ) || (r_state == ST_DROP);
  assign oIMEM_ADDR = r_fetch_pc;
  assign oVALID     = w_valid;
  // Head fields are masked to zero while the queue is empty.
  assign oINSTR     = w_valid ? w_head.instr : '0;
  assign oPC        = w_valid ? w_head.pc : '0;
  assign oOPCODE    = oINSTR[OPC_HI:OPC_LO];

endmodule

// File: tb/tb_instr_fetch_uni.sv
// Self-checking bench for instr_fetch_uni: directed fetch/redirect/reset
// scenarios with a scoreboard of expected decode-side entries.
module tb_instr_fetch_uni;

  logic        iCLK = 1'b0;
  logic        iRST_n;
  logic        oIMEM_REQ;
  logic [63:0] oIMEM_ADDR;
  logic        iIMEM_ACK;
  logic [31:0] iIMEM_DATA;
  logic        oVALID;
  logic        iREADY;
  logic [31:0] oINSTR;
  logic [10:0] oOPCODE;
  logic [63:0] oPC;
  logic        iREDIRECT;
  logic [63:0] iREDIRECT_PC;

  instr_fetch_uni #(.RESET_PC(64'h0), .DEPTH(4)) dut (
    .iCLK         (iCLK),
    .iRST_n       (iRST_n),
    .oIMEM_REQ    (oIMEM_REQ),
    .oIMEM_ADDR   (oIMEM_ADDR),
    .iIMEM_ACK    (iIMEM_ACK),
    .iIMEM_DATA   (iIMEM_DATA),
    .oVALID       (oVALID),
    .iREADY       (iREADY),
    .oINSTR       (oINSTR),
    .oOPCODE      (oOPCODE),
    .oPC          (oPC),
    .iREDIRECT    (iREDIRECT),
    .iREDIRECT_PC (iREDIRECT_PC)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  // Memory contents: opcode field of every word is 11'h458.
  function automatic logic [31:0] word(input logic [63:0] a);
    return 32'h8B00_0000 | {12'h0, a[19:0]};
  endfunction

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  // Ack the outstanding request at address a and expect its word at decode.
  task automatic ack_keep(input logic [63:0] a);
    exp_t e;
    chk("ack_req", {63'h0, oIMEM_REQ}, 64'h1);
    chk("ack_addr", oIMEM_ADDR, a);
    iIMEM_ACK  = 1'b1;
    iIMEM_DATA = word(a);
    e.pc    = a;
    e.instr = word(a);
    q.push_back(e);
    step();
    iIMEM_ACK = 1'b0;
  endtask

  // Monitor: every decode handshake must match the oldest expected entry.
  always @(negedge iCLK) begin
    if (iRST_n && oVALID && iREADY) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out: got pc 0x%0h required no entry", oPC);
      end else begin
        mon_e = q.pop_front();
        chk("out_pc", oPC, mon_e.pc);
        chk("out_instr", {32'h0, oINSTR}, {32'h0, mon_e.instr});
        chk("out_opcode", {53'h0, oOPCODE}, {53'h0, mon_e.instr[31:21]});
      end
    end
  end

  initial begin
    iRST_n = 1'b0; iREADY = 1'b0; iIMEM_ACK = 1'b0; iIMEM_DATA = '0;
    iREDIRECT = 1'b0; iREDIRECT_PC = '0;

    // Reset values
    #12;
    chk("rst_req",    {63'h0, oIMEM_REQ}, 64'h0);
    chk("rst_addr",   oIMEM_ADDR, 64'h0);
    chk("rst_valid",  {63'h0, oVALID}, 64'h0);
    chk("rst_instr",  {32'h0, oINSTR}, 64'h0);
    chk("rst_opcode", {53'h0, oOPCODE}, 64'h0);
    chk("rst_pc",     oPC, 64'h0);
    iRST_n = 1'b1;
    #1;
    chk("rel_req_low", {63'h0, oIMEM_REQ}, 64'h0);
    step();
    chk("first_req", {63'h0, oIMEM_REQ}, 64'h1);

    // Streaming: ack every cycle, decode always ready
    iREADY = 1'b1;
    ack_keep(64'h0);
    chk("first_valid",  {63'h0, oVALID}, 64'h1);
    chk("first_opcode", {53'h0, oOPCODE}, 64'h458);
    for (int i = 1; i < 8; i++) ack_keep(64'(i * 4));
    repeat (3) step();
    chk("stream_drained", {63'h0, oVALID}, 64'h0);
    chk("stream_addr",    oIMEM_ADDR, 64'd32);

    // Fill the queue with decode stalled
    iREADY = 1'b0;
    for (int i = 0; i < 4; i++) ack_keep(64'(32 + i * 4));
    chk("full_req_off", {63'h0, oIMEM_REQ}, 64'h0);
    step(); step();
    chk("full_req_hold", {63'h0, oIMEM_REQ}, 64'h0);
    chk("full_head_pc",  oPC, 64'd32);
    iREADY = 1'b1;
    step();
    iREADY = 1'b0;
    chk("resume_req",  {63'h0, oIMEM_REQ}, 64'h1);
    chk("resume_addr", oIMEM_ADDR, 64'd48);
    ack_keep(64'd48);
    chk("refull_req_off", {63'h0, oIMEM_REQ}, 64'h0);
    iREADY = 1'b1;
    repeat (4) step();
    chk("wrap_drained", {63'h0, oVALID}, 64'h0);
    chk("wrap_addr",    oIMEM_ADDR, 64'd52);

    // Redirect while a request is waiting: that ack is dropped
    iREDIRECT = 1'b1; iREDIRECT_PC = 64'h103;
    step();
    iREDIRECT = 1'b0;
    chk("drop_valid", {63'h0, oVALID}, 64'h0);
    chk("drop_req",   {63'h0, oIMEM_REQ}, 64'h1);
    chk("drop_addr",  oIMEM_ADDR, 64'd52);
    step(); step();
    chk("drop_wait_valid", {63'h0, oVALID}, 64'h0);
    iIMEM_ACK = 1'b1; iIMEM_DATA = 32'hDEAD_BEEF;
    step();
    iIMEM_ACK = 1'b0;
    chk("redir_addr",       oIMEM_ADDR, 64'h100);
    chk("redir_valid_low",  {63'h0, oVALID}, 64'h0);
    ack_keep(64'h100);
    chk("redir_valid", {63'h0, oVALID}, 64'h1);
    step();

    // Redirect, ack and dequeue in the same cycle
    iREADY = 1'b0;
    ack_keep(64'h104);
    ack_keep(64'h108);
    iREADY = 1'b1; iIMEM_ACK = 1'b1; iIMEM_DATA = 32'hDEAD_BEEF;
    iREDIRECT = 1'b1; iREDIRECT_PC = 64'h400;
    step();
    iREDIRECT = 1'b0; iIMEM_ACK = 1'b0; iREADY = 1'b0;
    q.delete();  // 0x108 is flushed; 0x104 was taken by decode
    chk("same_valid", {63'h0, oVALID}, 64'h0);
    chk("same_req",   {63'h0, oIMEM_REQ}, 64'h1);
    chk("same_addr",  oIMEM_ADDR, 64'h400);
    step();
    chk("same_empty", {63'h0, oVALID}, 64'h0);

    // Two redirects while dropping: only the last target is fetched
    iREDIRECT = 1'b1; iREDIRECT_PC = 64'h200;
    step();
    chk("drop2_addr_a", oIMEM_ADDR, 64'h400);
    iREDIRECT_PC = 64'h300;
    step();
    iREDIRECT = 1'b0;
    chk("drop2_addr_b", oIMEM_ADDR, 64'h400);
    iIMEM_ACK = 1'b1; iIMEM_DATA = 32'hDEAD_BEEF;
    step();
    iIMEM_ACK = 1'b0;
    chk("drop2_target", oIMEM_ADDR, 64'h300);
    iREADY = 1'b1;
    ack_keep(64'h300);
    step();

    // Reset in the middle of a request with an entry queued
    iREADY = 1'b0;
    ack_keep(64'h304);
    iRST_n = 1'b0;
    #1;
    chk("mid_rst_req",    {63'h0, oIMEM_REQ}, 64'h0);
    chk("mid_rst_addr",   oIMEM_ADDR, 64'h0);
    chk("mid_rst_valid",  {63'h0, oVALID}, 64'h0);
    chk("mid_rst_instr",  {32'h0, oINSTR}, 64'h0);
    chk("mid_rst_opcode", {53'h0, oOPCODE}, 64'h0);
    chk("mid_rst_pc",     oPC, 64'h0);
    step(); step();
    q.delete();  // queued 0x304 is lost by reset
    iRST_n = 1'b1;
    step();
    chk("post_rst_valid", {63'h0, oVALID}, 64'h0);
    chk("post_rst_req",   {63'h0, oIMEM_REQ}, 64'h1);
    chk("post_rst_addr",  oIMEM_ADDR, 64'h0);
    iREADY = 1'b1;
    ack_keep(64'h0);
    step(); step();
    chk("scoreboard_drained", 64'(q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
